// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit living in the Execute stage.
// Multiplies use radix-2 shift-add over 32 cycles, divides use restoring
// division over 32 cycles, followed by a sign-fixup cycle and a one-cycle
// DONE pulse. Divide-by-zero and signed overflow finish after one cycle.
// Optional build macro MULDIV_FAST_MUL_EN: funct3 0-3 complete through a
// single-cycle combinational multiplier instead of the iterative path.
module ex_muldiv #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flushE,
   input  logic            startE,
   input  logic [2:0]      funct3E,
   input  logic [XLEN-1:0] srcAE,
   input  logic [XLEN-1:0] srcBE,
   output logic            busyE,
   output logic            doneE,
   output logic [XLEN-1:0] resultE
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [2:0] F_MUL    = 3'd0;
   localparam logic [2:0] F_MULH   = 3'd1;
   localparam logic [2:0] F_MULHSU = 3'd2;
   localparam logic [2:0] F_MULHU  = 3'd3;
   localparam logic [2:0] F_DIV    = 3'd4;
   localparam logic [2:0] F_DIVU   = 3'd5;
   localparam logic [2:0] F_REM    = 3'd6;
   localparam logic [2:0] F_REMU   = 3'd7;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

   // two's-complement negation of a word
   function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
      return ~v + {{(XLEN-1){1'b0}}, 1'b1};
   endfunction

   // two's-complement negation of a double word
   function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] v);
      return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
   endfunction

   state_t            state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [2:0]        op_r;
   logic              neg_r;
   logic [XLEN-1:0]   opb_r;     // multiplicand |A| or divisor |B|
   logic [2*XLEN-1:0] acc_r;     // product, or {0, quotient/dividend}
   logic [XLEN-1:0]   rem_r;     // partial remainder (always < divisor)
   logic              done_r;
   logic [XLEN-1:0]   result_r;

   logic              a_sgn_s;
   logic              b_sgn_s;
   logic              a_neg_s;
   logic              b_neg_s;
   logic [XLEN-1:0]   mag_a_s;
   logic [XLEN-1:0]   mag_b_s;
   logic              sign_s;
   logic              special_s;
   logic [XLEN-1:0]   special_res_s;

   logic [XLEN:0]     mul_sum_s;
   logic [2*XLEN-1:0] mul_next_s;
   logic [XLEN:0]     div_shift_s;
   logic              div_ge_s;
   logic [XLEN-1:0]   div_rem_next_s;
   logic [XLEN-1:0]   div_quo_next_s;

   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s;
   logic [XLEN-1:0]   remv_s;
   logic [XLEN-1:0]   fix_res_s;
   logic              busy_s;

   // operand signedness, magnitudes, result sign and early-exit results
   always_comb begin
      a_sgn_s       = 1'b0;
      b_sgn_s       = 1'b0;
      special_s     = 1'b0;
      special_res_s = {XLEN{1'b0}};
      case (funct3E)
         F_MUL, F_MULH, F_DIV, F_REM: begin
            a_sgn_s = 1'b1;
            b_sgn_s = 1'b1;
         end
         F_MULHSU: begin
            a_sgn_s = 1'b1;
            b_sgn_s = 1'b0;
         end
         default: begin
            a_sgn_s = 1'b0;
            b_sgn_s = 1'b0;
         end
      endcase
      a_neg_s = a_sgn_s & srcAE[XLEN-1];
      b_neg_s = b_sgn_s & srcBE[XLEN-1];
      mag_a_s = a_neg_s ? neg_w(srcAE) : srcAE;
      mag_b_s = b_neg_s ? neg_w(srcBE) : srcBE;
      // remainder follows the dividend; everything else follows the product sign
      if (funct3E == F_REM) begin
         sign_s = a_neg_s;
      end else begin
         sign_s = a_neg_s ^ b_neg_s;
      end
      if (funct3E[2]) begin
         if (srcBE == {XLEN{1'b0}}) begin
            special_s     = 1'b1;
            special_res_s = funct3E[1] ? srcAE : {XLEN{1'b1}};
         end else if (!funct3E[0] && (srcAE == {1'b1, {(XLEN-1){1'b0}}})
                      && (srcBE == {XLEN{1'b1}})) begin
            special_s     = 1'b1;
            special_res_s = funct3E[1] ? {XLEN{1'b0}} : srcAE;
         end else begin
            special_s     = 1'b0;
            special_res_s = {XLEN{1'b0}};
         end
      end else begin
         special_s     = 1'b0;
         special_res_s = {XLEN{1'b0}};
      end
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_a_s;
   logic [2*XLEN-1:0] fast_b_s;
   logic [2*XLEN-1:0] fast_prod_s;
   logic [XLEN-1:0]   fast_res_s;

   // single-cycle signed/unsigned multiply via sign-extended operands
   always_comb begin
      fast_a_s    = {{XLEN{a_neg_s}}, srcAE};
      fast_b_s    = {{XLEN{b_neg_s}}, srcBE};
      fast_prod_s = fast_a_s * fast_b_s;
      if (funct3E == F_MUL) begin
         fast_res_s = fast_prod_s[XLEN-1:0];
      end else begin
         fast_res_s = fast_prod_s[2*XLEN-1:XLEN];
      end
   end
`endif

   // one shift-add step and one restoring-divide step
   always_comb begin
      mul_sum_s      = {1'b0, acc_r[2*XLEN-1:XLEN]}
                     + (acc_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
      mul_next_s     = {mul_sum_s, acc_r[XLEN-1:1]};
      div_shift_s    = {rem_r, acc_r[XLEN-1]};
      div_ge_s       = (div_shift_s >= {1'b0, opb_r});
      div_rem_next_s = div_ge_s ? (div_shift_s[XLEN-1:0] - opb_r) : div_shift_s[XLEN-1:0];
      div_quo_next_s = {acc_r[XLEN-2:0], div_ge_s};
   end

   // sign correction and final result selection
   always_comb begin
      prod_s = neg_r ? neg_dw(acc_r) : acc_r;
      quo_s  = neg_r ? neg_w(acc_r[XLEN-1:0]) : acc_r[XLEN-1:0];
      remv_s = neg_r ? neg_w(rem_r) : rem_r;
      case (op_r)
         F_MUL:                     fix_res_s = prod_s[XLEN-1:0];
         F_MULH, F_MULHSU, F_MULHU: fix_res_s = prod_s[2*XLEN-1:XLEN];
         F_DIV, F_DIVU:             fix_res_s = quo_s;
         F_REM, F_REMU:             fix_res_s = remv_s;
         default:                   fix_res_s = {XLEN{1'b0}};
      endcase
   end

   // stall request: start cycle in IDLE, whole of CALC and FIXUP
   always_comb begin
      case (state_r)
         IDLE:    busy_s = startE;
         CALC:    busy_s = 1'b1;
         FIXUP:   busy_s = 1'b1;
         DONE:    busy_s = 1'b0;
         default: busy_s = 1'b0;
      endcase
   end

   assign busyE   = busy_s & ~reset;
   assign doneE   = done_r;
   assign resultE = result_r;

   // control FSM and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r  <= IDLE;
         cnt_r    <= {CNT_W{1'b0}};
         op_r     <= 3'd0;
         neg_r    <= 1'b0;
         opb_r    <= {XLEN{1'b0}};
         acc_r    <= {(2*XLEN){1'b0}};
         rem_r    <= {XLEN{1'b0}};
         done_r   <= 1'b0;
         result_r <= {XLEN{1'b0}};
      end else if (flushE) begin
         state_r <= IDLE;
         cnt_r   <= {CNT_W{1'b0}};
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (startE) begin
                  op_r  <= funct3E;
                  neg_r <= sign_s;
                  cnt_r <= {CNT_W{1'b0}};
                  rem_r <= {XLEN{1'b0}};
                  if (funct3E[2]) begin
                     opb_r <= mag_b_s;
                     acc_r <= {{XLEN{1'b0}}, mag_a_s};
                  end else begin
                     opb_r <= mag_a_s;
                     acc_r <= {{XLEN{1'b0}}, mag_b_s};
                  end
                  if (special_s) begin
                     result_r <= special_res_s;
                     done_r   <= 1'b1;
                     state_r  <= DONE;
                  end
`ifdef MULDIV_FAST_MUL_EN
                  else if (!funct3E[2]) begin
                     result_r <= fast_res_s;
                     done_r   <= 1'b1;
                     state_r  <= DONE;
                  end
`endif
                  else begin
                     state_r <= CALC;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            CALC: begin
               if (op_r[2]) begin
                  rem_r <= div_rem_next_s;
                  acc_r <= {{XLEN{1'b0}}, div_quo_next_s};
               end else begin
                  acc_r <= mul_next_s;
               end
               cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               if (cnt_r == LAST_CNT) begin
                  state_r <= FIXUP;
               end else begin
                  state_r <= CALC;
               end
            end
            FIXUP: begin
               result_r <= fix_res_s;
               done_r   <= 1'b1;
               state_r  <= DONE;
            end
            DONE: begin
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
